// File: rtl/dmem_pipe.sv
// Single-port data memory with a one-deep registered response stage.
// Byte/half/word loads and stores, illegal requests answered with rsp_err.
module dmem_pipe #(
  parameter int DEPTH_WORDS = 256,
  parameter int INIT_INDEX  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [AW-1:0] mem_idx;
  logic [1:0]    lane;
  logic          req_err;
  logic          accept;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   load_val;
  logic [31:0]   word_view [DEPTH_WORDS];

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    mem_idx = req_addr[AW+1:2];
    lane    = req_addr[1:0];

    req_err = 1'b0;
    if (!(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
      req_err = 1'b1;
    if (req_we && req_funct3[2])
      req_err = 1'b1;
    if (req_funct3[1:0] == 2'b01 && lane[0])
      req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && lane != 2'b00)
      req_err = 1'b1;
    if (|req_addr[31:AW+2])
      req_err = 1'b1;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    case (req_funct3[1:0])
      2'b00: begin
        mem_be    = 4'b0001 << lane;
        mem_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        mem_be    = lane[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = req_wdata;
      end
    endcase

    rd_word  = word_view[mem_idx];
    rd_shift = rd_word >> {lane, 3'b000};
    case (req_funct3)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_val = {24'd0, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_val = {16'd0, rd_shift[15:0]};
      default: load_val = rd_word;
    endcase

    accept = req_valid && req_ready && rst_n;
    mem_we = accept && req_we && !req_err;

    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = req_err;
      rsp_rdata_d = (req_err || req_we) ? 32'd0 : load_val;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage carries a power-up value and is deliberately untouched by rst_n.
  for (genvar i = 0; i < DEPTH_WORDS; i++) begin : g_word
    logic [31:0] word_q = (INIT_INDEX != 0) ? 32'(i) : 32'd0;

    always_ff @(posedge clk) begin
      if (mem_we && mem_idx == AW'(i)) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b])
            word_q[8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end

    assign word_view[i] = word_q;
  end

endmodule

// File: tb/tb_dmem_pipe.sv
// Self-checking bench for dmem_pipe: directed vector table, multi-cycle
// corner sequences, and random traffic against a byte-level memory model.
module tb_dmem_pipe;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [DEPTH];

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  dmem_pipe #(.DEPTH_WORDS(DEPTH), .INIT_INDEX(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: memory as an array of words, accessed by byte arithmetic.
  function automatic void model_access(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er);
    int unsigned idx  = addr / 4;
    int unsigned bofs = addr % 4;
    int unsigned size;
    logic [31:0] v;
    er = 1'b0;
    rd = 32'd0;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default: begin size = 1; er = 1'b1; end
    endcase
    if (addr % size != 0) er = 1'b1;
    if (we && f3 >= 3'd4) er = 1'b1;
    if (addr >= 32'(4 * DEPTH)) er = 1'b1;
    if (er) return;
    if (we) begin
      for (int b = 0; b < int'(size); b++)
        model_mem[idx][8*(int'(bofs) + b) +: 8] = wd[8*b +: 8];
    end else begin
      v = model_mem[idx] >> (8 * bofs);
      case (f3)
        3'd0:    rd = 32'($signed(v[7:0]));
        3'd4:    rd = v % 256;
        3'd1:    rd = 32'($signed(v[15:0]));
        3'd5:    rd = v % 65536;
        default: rd = v;
      endcase
    end
  endfunction

  task automatic set_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  // One request; response held with rsp_ready low for `stall` cycles, then released.
  task automatic applyStimulus(input string name, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd, input int stall,
                               input logic [31:0] exp_rd, input logic exp_er);
    set_req(we, f3, addr, wd);
    rsp_ready = 1'b1;
    #1;
    check32({name, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = (stall == 0);
    checkOutput(name, exp_rd, exp_er);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      checkOutput({name, ".hold"}, exp_rd, exp_er);
      check32({name, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_rd, input logic exp_er);
    check32({name, ".valid"}, 32'(rsp_valid), 32'd1);
    check32({name, ".rdata"}, rsp_rdata, exp_rd);
    check32({name, ".err"}, 32'(rsp_err), 32'(exp_er));
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] mrd;
    logic        mer;
    logic [31:0] stream_addr [8];
    logic [31:0] stream_exp [8];
    logic [2:0]  legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  bad_f3 [3]   = '{3'd3, 3'd6, 3'd7};

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'(i);

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check32("reset.valid", 32'(rsp_valid), 32'd0);
    check32("reset.rdata", rsp_rdata, 32'd0);
    check32("reset.err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    #1;
    check32("reset.ready", 32'(req_ready), 32'd1);

    vecs.push_back('{"lw10",     0, 3'd2, 32'h10,  32'h0,        32'h00000004, 0});
    vecs.push_back('{"sw20",     1, 3'd2, 32'h20,  32'h800000F0, 32'h0,        0});
    vecs.push_back('{"lb23",     0, 3'd0, 32'h23,  32'h0,        32'hFFFFFF80, 0});
    vecs.push_back('{"lbu23",    0, 3'd4, 32'h23,  32'h0,        32'h00000080, 0});
    vecs.push_back('{"lhu22",    0, 3'd5, 32'h22,  32'h0,        32'h00008000, 0});
    vecs.push_back('{"lh22",     0, 3'd1, 32'h22,  32'h0,        32'hFFFF8000, 0});
    vecs.push_back('{"lh20",     0, 3'd1, 32'h20,  32'h0,        32'h000000F0, 0});
    vecs.push_back('{"sb21",     1, 3'd0, 32'h21,  32'h123456AB, 32'h0,        0});
    vecs.push_back('{"lw20a",    0, 3'd2, 32'h20,  32'h0,        32'h8000ABF0, 0});
    vecs.push_back('{"sh21",     1, 3'd1, 32'h21,  32'hFFFFFFFF, 32'h0,        1});
    vecs.push_back('{"lw22",     0, 3'd2, 32'h22,  32'h0,        32'h0,        1});
    vecs.push_back('{"f3_011",   1, 3'd3, 32'h20,  32'h11111111, 32'h0,        1});
    vecs.push_back('{"sb_f3_100",1, 3'd4, 32'h20,  32'h22222222, 32'h0,        1});
    vecs.push_back('{"lw400",    0, 3'd2, 32'h400, 32'h0,        32'h0,        1});
    vecs.push_back('{"sw400",    1, 3'd2, 32'h400, 32'h33333333, 32'h0,        1});
    vecs.push_back('{"lw20b",    0, 3'd2, 32'h20,  32'h0,        32'h8000ABF0, 0});
    vecs.push_back('{"lw00",     0, 3'd2, 32'h0,   32'h0,        32'h00000000, 0});
    for (int i = 0; i < vecs.size(); i++) begin
      model_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, mrd, mer);
      applyStimulus(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    0, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Backpressure: response held for three cycles, then swapped for a new one.
    set_req(0, 3'd2, 32'h0C, 32'h0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checkOutput("bp.first", 32'h3, 1'b0);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      checkOutput("bp.hold", 32'h3, 1'b0);
      check32("bp.hold_ready", 32'(req_ready), 32'd0);
    end
    set_req(0, 3'd2, 32'h10, 32'h0);
    rsp_ready = 1'b1;
    #1;
    check32("bp.release_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("bp.next", 32'h4, 1'b0);
    @(posedge clk); #1;
    check32("bp.drained", 32'(rsp_valid), 32'd0);

    // Eight back-to-back loads, one response per cycle.
    for (int k = 0; k < 8; k++) begin
      stream_addr[k] = 32'($urandom_range(0, DEPTH - 1)) * 4;
      model_access(0, 3'd2, stream_addr[k], 32'h0, stream_exp[k], mer);
    end
    set_req(0, 3'd2, stream_addr[0], 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stream%0d", k), stream_exp[k], 1'b0);
      if (k < 7) set_req(0, 3'd2, stream_addr[k+1], 32'h0);
      else req_valid = 1'b0;
    end
    @(posedge clk); #1;
    check32("stream.end", 32'(rsp_valid), 32'd0);

    // Reset while a store response is pending: response dropped, store kept.
    set_req(1, 3'd2, 32'h30, 32'h12345678);
    model_access(1, 3'd2, 32'h30, 32'h12345678, mrd, mer);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check32("rst.pending", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check32("rst.dropped", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check32("rst.ready", 32'(req_ready), 32'd1);
    applyStimulus("rst.lw30", 0, 3'd2, 32'h30, 32'h0, 0, 32'h12345678, 1'b0);

    // Random traffic, concentrated on a few words to exercise store->load reuse.
    for (int n = 0; n < 400; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      int          stall;
      int unsigned idx;
      idx  = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
      addr = 32'(idx * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) addr = addr | (32'h1 << $urandom_range(10, 31));
      f3    = ($urandom_range(0, 9) == 0) ? bad_f3[$urandom_range(0, 2)] : legal_f3[$urandom_range(0, 4)];
      we    = 1'($urandom_range(0, 1));
      wd    = $urandom;
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      model_access(we, f3, addr, wd, mrd, mer);
      applyStimulus($sformatf("rnd%0d", n), we, f3, addr, wd, stall, mrd, mer);
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
